axist_test_seq: RTL

Autonomous test sequencer that drives the AXIST CSR register port to run one complete loopback test: pulse the AXIST datapath reset, wait for link-up, program delay values and the packet-generator control, then poll checker status until pass, fail or timeout. It sits between the host/JTAG start trigger and the CSR controller, replacing manual register scripting in full-example builds.

---
 rtl/axist_seq_pkg.sv | 36 +++
 rtl/axist_seq_timer.sv | 44 ++++
 rtl/axist_test_seq.sv | 222 ++++++++++++++++++++++
 3 files changed

// File: rtl/axist_seq_pkg.sv
// rtl/axist_seq_pkg.sv - CSR map, sequencer states and fail codes for axist_test_seq
package axist_seq_pkg;

  localparam logic [15:0] ADDR_AXI_CTRL      = 16'h3000;
  localparam logic [15:0] ADDR_TX_PKT_CTRL   = 16'h1000;
  localparam logic [15:0] ADDR_RX_CKR_STS    = 16'h1004;
  localparam logic [15:0] ADDR_LINKUP_SINGLE = 16'h1008;
  localparam logic [15:0] ADDR_DELAY_X       = 16'h2000;
  localparam logic [15:0] ADDR_DELAY_Y       = 16'h2004;
  localparam logic [15:0] ADDR_DELAY_Z       = 16'h2008;
  // Dual-direction map: F2L packet control takes over 0x1008, link-up moves up
  localparam logic [15:0] ADDR_F2L_PKT_CTRL  = 16'h1008;
  localparam logic [15:0] ADDR_RX_F2L_STS    = 16'h100C;
  localparam logic [15:0] ADDR_LINKUP_DUAL   = 16'h1010;

  localparam logic [2:0] FC_PASS      = 3'd0;
  localparam logic [2:0] FC_LINK_TMO  = 3'd1;
  localparam logic [2:0] FC_CHK_TMO   = 3'd2;
  localparam logic [2:0] FC_CHK_FAIL  = 3'd3;
  localparam logic [2:0] FC_ALIGN     = 3'd4;
  localparam logic [2:0] FC_RD_NORESP = 3'd5;

  typedef enum logic [4:0] {
    S_IDLE, S_RST_ON, S_RST_OFF, S_LINK_RD, S_LINK_WAIT, S_LINK_GAP,
    S_WR_DX, S_WR_DY, S_WR_DZ, S_WR_PKT, S_WR_F2L,
    S_CHK_RD, S_CHK_WAIT, S_CHK_RD2, S_CHK_WAIT2, S_CHK_GAP, S_FINISH
  } seq_state_t;

  // Result of a checker status word that already reports done
  function automatic logic [2:0] chk_code(input logic [3:0] sts);
    if (!sts[3])      return FC_ALIGN;
    else if (!sts[0]) return FC_CHK_FAIL;
    else              return FC_PASS;
  endfunction

endpackage

// File: rtl/axist_seq_timer.sv
// rtl/axist_seq_timer.sv - poll gap down-counter and saturating poll/timeout counter
module axist_seq_timer
  import axist_seq_pkg::*;
#(
  parameter int POLL_GAP = 16,
  parameter int TIMEOUT  = 1024
) (
  input  logic clk,
  input  logic rst_n,
  input  logic gap_load,
  input  logic gap_run,
  input  logic poll_clr,
  input  logic poll_inc,
  output logic gap_expire,
  output logic poll_expire
);

  localparam int GW = $clog2(POLL_GAP + 1);
  localparam int PW = $clog2(TIMEOUT + 1);

  logic [GW-1:0] gap_cnt;
  logic [PW-1:0] poll_cnt;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      gap_cnt  <= '0;
      poll_cnt <= '0;
    end else begin
      if (gap_load)
        gap_cnt <= GW'(POLL_GAP);
      else if (gap_run && gap_cnt != '0)
        gap_cnt <= gap_cnt - GW'(1);
      // Saturate at TIMEOUT so the counter can never wrap back to "fresh"
      if (poll_clr)
        poll_cnt <= '0;
      else if (poll_inc && poll_cnt != PW'(TIMEOUT))
        poll_cnt <= poll_cnt + PW'(1);
    end
  end

  assign gap_expire  = (gap_cnt == GW'(1));
  assign poll_expire = (poll_cnt == PW'(TIMEOUT));

endmodule

// File: rtl/axist_test_seq.sv
// rtl/axist_test_seq.sv - autonomous AXIST loopback test sequencer driving the CSR port
// Optional dual-direction checking (F2L generator + second checker) under AXIST_SEQ_DUAL_EN.
module axist_test_seq
  import axist_seq_pkg::*;
#(
  parameter int POLL_GAP = 16,
  parameter int TIMEOUT  = 1024
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [31:0] cfg_delay_x,
  input  logic [31:0] cfg_delay_y,
  input  logic [31:0] cfg_delay_z,
  input  logic [31:0] cfg_pkt_ctrl,
`ifdef AXIST_SEQ_DUAL_EN
  input  logic [31:0] cfg_f2l_pkt_ctrl,
`endif
  output logic [15:0] csr_addr,
  output logic        csr_wr_en,
  output logic        csr_rd_en,
  output logic [31:0] csr_wr_data,
  input  logic [31:0] csr_rd_data,
  input  logic        csr_rd_dvalid,
  output logic        busy,
  output logic        done,
  output logic        pass,
  output logic [2:0]  fail_code
);

`ifdef AXIST_SEQ_DUAL_EN
  localparam logic [15:0] ADDR_LINKUP = ADDR_LINKUP_DUAL;
  logic [3:0] sts1_q;
  logic       sts1_load;
`else
  localparam logic [15:0] ADDR_LINKUP = ADDR_LINKUP_SINGLE;
`endif

  seq_state_t state, nxt;
  logic       pass_q;
  logic [2:0] code_q;
  logic       res_load;
  logic [2:0] res_code;
  logic       gap_load, gap_run, poll_clr, poll_inc;
  logic       gap_expire, poll_expire;
  logic       unused_rd;

  assign unused_rd = ^csr_rd_data[31:4];

  axist_seq_timer #(.POLL_GAP(POLL_GAP), .TIMEOUT(TIMEOUT)) u_timer (
    .clk         (clk),
    .rst_n       (rst_n),
    .gap_load    (gap_load),
    .gap_run     (gap_run),
    .poll_clr    (poll_clr),
    .poll_inc    (poll_inc),
    .gap_expire  (gap_expire),
    .poll_expire (poll_expire)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state  <= S_IDLE;
      pass_q <= 1'b0;
      code_q <= FC_PASS;
    end else begin
      state <= nxt;
      if (state == S_IDLE && start) begin
        pass_q <= 1'b0;
        code_q <= FC_PASS;
      end else if (res_load) begin
        pass_q <= (res_code == FC_PASS);
        code_q <= res_code;
      end
    end
  end

`ifdef AXIST_SEQ_DUAL_EN
  always_ff @(posedge clk) begin
    if (!rst_n)
      sts1_q <= '0;
    else if (sts1_load)
      sts1_q <= csr_rd_data[3:0];
  end
`endif

  always_comb begin
    nxt         = state;
    csr_addr    = 16'h0;
    csr_wr_en   = 1'b0;
    csr_rd_en   = 1'b0;
    csr_wr_data = 32'h0;
    gap_load    = 1'b0;
    gap_run     = 1'b0;
    poll_clr    = 1'b0;
    poll_inc    = 1'b0;
    res_load    = 1'b0;
    res_code    = FC_PASS;
    done        = 1'b0;
`ifdef AXIST_SEQ_DUAL_EN
    sts1_load   = 1'b0;
`endif
    case (state)
      S_IDLE: if (start) nxt = S_RST_ON;
      S_RST_ON: begin
        csr_addr = ADDR_AXI_CTRL; csr_wr_en = 1'b1; csr_wr_data = 32'h1;
        nxt = S_RST_OFF;
      end
      S_RST_OFF: begin
        csr_addr = ADDR_AXI_CTRL; csr_wr_en = 1'b1;
        poll_clr = 1'b1;
        nxt = S_LINK_RD;
      end
      S_LINK_RD: begin
        csr_addr = ADDR_LINKUP; csr_rd_en = 1'b1; poll_inc = 1'b1;
        nxt = S_LINK_WAIT;
      end
      S_LINK_WAIT: begin
        if (!csr_rd_dvalid) begin
          res_load = 1'b1; res_code = FC_RD_NORESP; nxt = S_FINISH;
        end else if (csr_rd_data[3:0] == 4'hF) begin
          nxt = S_WR_DX;
        end else if (poll_expire) begin
          res_load = 1'b1; res_code = FC_LINK_TMO; nxt = S_FINISH;
        end else begin
          gap_load = 1'b1; nxt = S_LINK_GAP;
        end
      end
      S_LINK_GAP: begin
        gap_run = 1'b1;
        if (gap_expire) nxt = S_LINK_RD;
      end
      S_WR_DX: begin
        csr_addr = ADDR_DELAY_X; csr_wr_en = 1'b1; csr_wr_data = cfg_delay_x;
        nxt = S_WR_DY;
      end
      S_WR_DY: begin
        csr_addr = ADDR_DELAY_Y; csr_wr_en = 1'b1; csr_wr_data = cfg_delay_y;
        nxt = S_WR_DZ;
      end
      S_WR_DZ: begin
        csr_addr = ADDR_DELAY_Z; csr_wr_en = 1'b1; csr_wr_data = cfg_delay_z;
        nxt = S_WR_PKT;
      end
      S_WR_PKT: begin
        csr_addr = ADDR_TX_PKT_CTRL; csr_wr_en = 1'b1;
        csr_wr_data = {cfg_pkt_ctrl[31:1], 1'b1};
        poll_clr = 1'b1;
`ifdef AXIST_SEQ_DUAL_EN
        nxt = S_WR_F2L;
`else
        nxt = S_CHK_RD;
`endif
      end
`ifdef AXIST_SEQ_DUAL_EN
      S_WR_F2L: begin
        csr_addr = ADDR_F2L_PKT_CTRL; csr_wr_en = 1'b1;
        csr_wr_data = {cfg_f2l_pkt_ctrl[31:1], 1'b1};
        poll_clr = 1'b1;
        nxt = S_CHK_RD;
      end
`endif
      S_CHK_RD: begin
        csr_addr = ADDR_RX_CKR_STS; csr_rd_en = 1'b1; poll_inc = 1'b1;
        nxt = S_CHK_WAIT;
      end
`ifdef AXIST_SEQ_DUAL_EN
      S_CHK_WAIT: begin
        if (!csr_rd_dvalid) begin
          res_load = 1'b1; res_code = FC_RD_NORESP; nxt = S_FINISH;
        end else begin
          sts1_load = 1'b1; nxt = S_CHK_RD2;
        end
      end
      S_CHK_RD2: begin
        csr_addr = ADDR_RX_F2L_STS; csr_rd_en = 1'b1;
        nxt = S_CHK_WAIT2;
      end
      S_CHK_WAIT2: begin
        if (!csr_rd_dvalid) begin
          res_load = 1'b1; res_code = FC_RD_NORESP; nxt = S_FINISH;
        end else if (sts1_q[1] && csr_rd_data[1]) begin
          // First checker's verdict wins when both report a problem
          res_load = 1'b1; nxt = S_FINISH;
          res_code = (chk_code(sts1_q) != FC_PASS) ? chk_code(sts1_q)
                                                   : chk_code(csr_rd_data[3:0]);
        end else if (poll_expire) begin
          res_load = 1'b1; res_code = FC_CHK_TMO; nxt = S_FINISH;
        end else begin
          gap_load = 1'b1; nxt = S_CHK_GAP;
        end
      end
`else
      S_CHK_WAIT: begin
        if (!csr_rd_dvalid) begin
          res_load = 1'b1; res_code = FC_RD_NORESP; nxt = S_FINISH;
        end else if (csr_rd_data[1]) begin
          res_load = 1'b1; res_code = chk_code(csr_rd_data[3:0]); nxt = S_FINISH;
        end else if (poll_expire) begin
          res_load = 1'b1; res_code = FC_CHK_TMO; nxt = S_FINISH;
        end else begin
          gap_load = 1'b1; nxt = S_CHK_GAP;
        end
      end
`endif
      S_CHK_GAP: begin
        gap_run = 1'b1;
        if (gap_expire) nxt = S_CHK_RD;
      end
      S_FINISH: begin
        done = 1'b1;
        nxt  = S_IDLE;
      end
      default: nxt = S_IDLE;
    endcase
  end

  assign busy      = (state != S_IDLE);
  assign pass      = pass_q;
  assign fail_code = code_q;

endmodule
